// File: rtl/leds_pio_write_arb.sv
// Round-robin arbiter that serialises LED pattern writes from several requesters onto the PIO s1 slave.
// Optional readback verification is compiled in with `define LEDS_PIO_WRITE_ARB_VERIFY_EN.
module leds_pio_write_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 14,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      busy,
  output logic [IDX_W-1:0]          owner,
  output logic [DATA_W-1:0]         led_shadow,
  output logic                      err,
  input  logic                      err_clr,
  output logic [1:0]                pio_address,
  output logic                      pio_chipselect,
  output logic                      pio_write_n,
  output logic [31:0]               pio_writedata,
  input  logic [31:0]               pio_readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   grant_idx_r;
  logic [IDX_W-1:0]   win_idx_s;
  logic [DATA_W-1:0]  data_r;
  logic [DATA_W-1:0]  win_data_s;
  logic [NUM_REQ-1:0] ack_nxt_s;
  logic               cs_nxt_s;
  logic               wn_nxt_s;
  logic               any_req_s;

  // First set request bit scanning upward from the pointer, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] sh;
    logic               found;
    int                 idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sh  = r >> idx;
      if (!found && sh[0]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur);
    int nxt;
    nxt = (int'(cur) + 1) % NUM_REQ;
    return IDX_W'(nxt);
  endfunction

  assign any_req_s  = |req;
  assign win_idx_s  = rr_pick(req, rr_ptr_r);
  assign win_data_s = DATA_W'(req_data >> (int'(win_idx_s) * DATA_W));

  // Next-state sequencing.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifdef LEDS_PIO_WRITE_ARB_VERIFY_EN
      WRITE:   state_nxt_s = READ;
      READ:    state_nxt_s = ACK;
`else
      WRITE:   state_nxt_s = ACK;
`endif
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output values for the coming state, registered below so the bus sees only flops.
  always_comb begin
    cs_nxt_s  = 1'b0;
    wn_nxt_s  = 1'b1;
    ack_nxt_s = {NUM_REQ{1'b0}};
    case (state_nxt_s)
      WRITE: begin
        cs_nxt_s = 1'b1;
        wn_nxt_s = 1'b0;
      end
      READ: begin
        cs_nxt_s = 1'b1;
        wn_nxt_s = 1'b1;
      end
      ACK: begin
        ack_nxt_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_r;
      end
      default: begin
        cs_nxt_s  = 1'b0;
        wn_nxt_s  = 1'b1;
        ack_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State register and bus strobes; reset drops the strobes without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      busy           <= 1'b0;
      ack            <= {NUM_REQ{1'b0}};
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= 2'b00;
    end else begin
      state_r        <= state_nxt_s;
      busy           <= (state_nxt_s != IDLE);
      ack            <= ack_nxt_s;
      pio_chipselect <= cs_nxt_s;
      pio_write_n    <= wn_nxt_s;
      pio_address    <= 2'b00;
    end
  end

  // Winner index and pattern are captured at grant, so a requester may drop early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_idx_r   <= {IDX_W{1'b0}};
      data_r        <= {DATA_W{1'b0}};
      pio_writedata <= 32'h0000_0000;
    end else if (state_r == IDLE && any_req_s) begin
      grant_idx_r   <= win_idx_s;
      data_r        <= win_data_s;
      pio_writedata <= {{(32-DATA_W){1'b0}}, win_data_s};
    end else begin
      grant_idx_r   <= grant_idx_r;
      data_r        <= data_r;
      pio_writedata <= pio_writedata;
    end
  end

  // Owner/shadow follow the write; the pointer moves past the owner once it is acked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= {IDX_W{1'b0}};
      led_shadow <= {DATA_W{1'b0}};
      rr_ptr_r   <= {IDX_W{1'b0}};
    end else begin
      if (state_r == WRITE) begin
        owner      <= grant_idx_r;
        led_shadow <= data_r;
      end else begin
        owner      <= owner;
        led_shadow <= led_shadow;
      end
      if (state_r == ACK) begin
        rr_ptr_r <= rr_next(owner);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

`ifdef LEDS_PIO_WRITE_ARB_VERIFY_EN
  logic mismatch_s;
  logic err_r;

  assign mismatch_s = (pio_readdata[DATA_W-1:0] != data_r) || (|pio_readdata[31:DATA_W]);

  // Sticky readback error; a fresh mismatch outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (state_r == READ && mismatch_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  logic unused_s;
  assign unused_s = ^{err_clr, pio_readdata};
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_leds_pio_write_arb.sv
// Self-checking bench for leds_pio_write_arb: transaction-level round-robin model plus a PIO register model.
module tb_leds_pio_write_arb;

`ifdef LEDS_PIO_WRITE_ARB_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [55:0] req_data = 56'h0;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  owner;
  logic [13:0] led_shadow;
  logic        err;
  logic        err_clr = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;

  logic [13:0] pio_reg = 14'h0000;
  logic        bad_read = 1'b0;
  logic [31:0] bad_val = 32'h0000_0000;
  logic [13:0] pat [4];
  int          ptr = 0;
  int          checks = 0;
  int          errors = 0;

  leds_pio_write_arb dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack), .busy(busy),
    .owner(owner), .led_shadow(led_shadow), .err(err), .err_clr(err_clr),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .pio_readdata(pio_readdata)
  );

  always #5 clk = ~clk;

  // PIO slave: out_port register, combinational readback, optional corrupted readback.
  always @(posedge clk)
    if (pio_chipselect && !pio_write_n && pio_address == 2'b00) pio_reg <= pio_writedata[13:0];
  assign pio_readdata = bad_read ? bad_val : (pio_chipselect ? {18'h0, pio_reg} : 32'h0);

  function automatic int model_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (((r >> ((p + k) % 4)) & 4'b0001) != 4'b0000) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic set_data();
    req_data = {pat[3], pat[2], pat[1], pat[0]};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr = 0;
  endtask

  // Called at a negedge of an IDLE cycle with req already driven.
  task automatic expect_txn(input int exp_idx, input logic [13:0] exp_data,
                            input logic [3:0] drop_mask, input logic clr_in_read, input string name);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << exp_idx;
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0 || pio_address !== 2'b00) begin
      errors++;
      $display("FAIL %s write_strobe: cs=%b wn=%b addr=%0d, expected cs=1 wn=0 addr=0",
               name, pio_chipselect, pio_write_n, pio_address);
    end
    checks++;
    if (pio_writedata !== {18'h0, exp_data}) begin
      errors++;
      $display("FAIL %s writedata: got %h expected %h", name, pio_writedata, {18'h0, exp_data});
    end
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s write_cycle: ack=%b busy=%b, expected ack=0000 busy=1", name, ack, busy);
    end
    req = req & ~drop_mask;
    for (int i = 0; i < 4; i++)
      if (drop_mask[i]) req_data[i*14 +: 14] = ~req_data[i*14 +: 14];
`ifdef LEDS_PIO_WRITE_ARB_VERIFY_EN
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b1 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL %s read_cycle: cs=%b wn=%b ack=%b, expected cs=1 wn=1 ack=0000",
               name, pio_chipselect, pio_write_n, ack);
    end
    err_clr = clr_in_read;
`else
    err_clr = clr_in_read;
`endif
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (ack !== exp_ack) begin
      errors++;
      $display("FAIL %s ack: got %b expected %b", name, ack, exp_ack);
    end
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_strobes: cs=%b wn=%b, expected cs=0 wn=1", name, pio_chipselect, pio_write_n);
    end
    checks++;
    if (owner !== 2'(exp_idx) || led_shadow !== exp_data || pio_reg !== exp_data) begin
      errors++;
      $display("FAIL %s result: owner=%0d shadow=%h out_port=%h, expected owner=%0d data=%h",
               name, owner, led_shadow, pio_reg, exp_idx, exp_data);
    end
    ptr = (exp_idx + 1) % 4;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0 || pio_chipselect !== 1'b0) begin
      errors++;
      $display("FAIL %s post_ack: ack=%b busy=%b cs=%b, expected 0000/0/0", name, ack, busy, pio_chipselect);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || led_shadow !== 14'h0 ||
          ack !== 4'b0000 || owner !== 2'd0 || err !== 1'b0 || pio_writedata !== 32'h0 || pio_address !== 2'b00) begin
        errors++;
        $display("FAIL reset_idle: busy=%b cs=%b wn=%b shadow=%h ack=%b owner=%0d err=%b wd=%h, expected idle zeros",
                 busy, pio_chipselect, pio_write_n, led_shadow, ack, owner, err, pio_writedata);
      end
    end
  endtask

  task automatic test_single();
    pat[0] = 14'h1555; pat[1] = 14'h0; pat[2] = 14'h0; pat[3] = 14'h0;
    set_data();
    req = 4'b0001;
    expect_txn(model_winner(req, ptr), pat[model_winner(req, ptr)], 4'b0000, 1'b0, "single");
    req = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int w;
    do_reset();
    pat[0] = 14'h0111; pat[1] = 14'h0222; pat[2] = 14'h0333; pat[3] = 14'h0444;
    set_data();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      w = model_winner(req, ptr);
      expect_txn(w, pat[w], 4'b0000, 1'b0, "rr_held");
    end
    req = 4'b0000;
  endtask

  task automatic test_drop();
    pat[2] = 14'(($urandom & 32'h3FFF) | 32'h1);
    set_data();
    req = 4'b0100;
    expect_txn(model_winner(req, ptr), pat[2], 4'b0100, 1'b0, "drop");
    req = 4'b0000;
  endtask

  task automatic test_err();
    int w;
    pat[1] = 14'h0002;
    set_data();
    bad_val = 32'h0000_0001;
    bad_read = 1'b1;
    req = 4'b0010;
    w = model_winner(req, ptr);
    expect_txn(w, pat[w], 4'b0000, 1'b0, "err_low");
    req = 4'b0000; bad_read = 1'b0;
    checks++;
    if (err !== VERIFY) begin errors++; $display("FAIL err_set: got %b expected %b", err, VERIFY); end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== VERIFY) begin errors++; $display("FAIL err_sticky: got %b expected %b", err, VERIFY); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err); end
    bad_read = 1'b1; set_data(); req = 4'b0010;
    w = model_winner(req, ptr);
    expect_txn(w, pat[w], 4'b0000, 1'b1, "err_clr_coincident");
    req = 4'b0000; bad_read = 1'b0;
    checks++;
    if (err !== VERIFY) begin errors++; $display("FAIL err_set_wins: got %b expected %b", err, VERIFY); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    bad_val = 32'h0004_0002; bad_read = 1'b1; req = 4'b0010;
    w = model_winner(req, ptr);
    expect_txn(w, pat[w], 4'b0000, 1'b0, "err_upper");
    req = 4'b0000; bad_read = 1'b0;
    checks++;
    if (err !== VERIFY) begin errors++; $display("FAIL err_upper_bits: got %b expected %b", err, VERIFY); end
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    req = 4'b0010;
    w = model_winner(req, ptr);
    expect_txn(w, pat[w], 4'b0000, 1'b0, "err_good");
    req = 4'b0000;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_good_read: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid();
    int w;
    pat[1] = 14'h0A0A; pat[2] = 14'h0B0B; pat[3] = 14'h0C0C;
    set_data();
    req = 4'b0010;
    w = model_winner(req, ptr);
    expect_txn(w, pat[w], 4'b0000, 1'b0, "pre_abort");
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b1 || pio_write_n !== 1'b0) begin
      errors++;
      $display("FAIL abort_write_seen: cs=%b wn=%b expected cs=1 wn=0", pio_chipselect, pio_write_n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL abort_async: cs=%b wn=%b busy=%b ack=%b expected 0/1/0/0000",
               pio_chipselect, pio_write_n, busy, ack);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_ack: ack=%b busy=%b expected 0000/0", ack, busy);
    end
    req = 4'b1010;
    reset = 1'b0;
    ptr = 0;
    w = model_winner(req, ptr);
    expect_txn(w, pat[w], 4'b0000, 1'b0, "post_abort");
    req = 4'b0000;
  endtask

  task automatic test_random();
    int w;
    logic [3:0] r;
    logic [3:0] dm;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) pat[i] = 14'($urandom);
      set_data();
      r = 4'($urandom_range(1, 15));
      req = r;
      w = model_winner(r, ptr);
      dm = ($urandom_range(0, 3) == 0) ? (4'b0001 << w) : 4'b0000;
      expect_txn(w, pat[w], dm, 1'b0, "random");
    end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_err();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
